// File: rtl/packet_filter_pkg.sv
// Shared types and register map for the host-driven frame source.
// Imported by the transmitter top level and its byte buffer.
package packet_filter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_t;

    localparam logic [7:0] TX_CTRL   = 8'd0;
    localparam logic [7:0] TX_DATA   = 8'd1;
    localparam logic [7:0] TX_GAP    = 8'd2;
    localparam logic [7:0] TX_STATUS = 8'd3;
    localparam logic [7:0] TX_FILL   = 8'd4;
    localparam logic [7:0] TX_FRAMES = 8'd5;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;

    // The FILL register is 8 bits wide, so a full 256-byte buffer reads as 255.
    function automatic logic [7:0] sat_fill(input logic [31:0] n);
        return (n > 32'd255) ? 8'hFF : n[7:0];
    endfunction

endpackage

// File: rtl/tx_byte_buffer.sv
// Circular byte store: one-byte push, one- or two-byte pop, occupancy flags.
// The two head bytes are presented combinationally for beat assembly.
module tx_byte_buffer
    import packet_filter_pkg::*;
#(
    parameter  int BUF_BYTES = 256,
    localparam int PTR_W     = $clog2(BUF_BYTES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [7:0]       push_data_i,
    input  logic             pop_i,
    input  logic             pop_two_i,
    output logic [7:0]       rd_byte0_o,
    output logic [7:0]       rd_byte1_o,
    output logic [PTR_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [7:0]       mem_q [BUF_BYTES];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W:0]   pop_n;
    logic             push_ok;

    // Fullness is judged on the registered count, so a same-cycle pop never frees room.
    assign full_o     = (count_q == (PTR_W+1)'(BUF_BYTES));
    assign empty_o    = (count_q == '0);
    assign push_ok    = push_i && !full_o;
    assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
    assign rd_byte0_o = mem_q[rd_ptr_q];
    assign rd_byte1_o = mem_q[rd_ptr_nxt];
    assign count_o    = count_q;

    always_comb begin
        pop_n = '0;
        if (pop_i) begin
            pop_n = pop_two_i ? (PTR_W+1)'(2) : (PTR_W+1)'(1);
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + pop_n[PTR_W-1:0];
        count_d  = count_q + (PTR_W+1)'(push_ok) - pop_n;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/frame_transmitter.sv
// Host-loaded frame source: Avalon-MM register file fills a byte buffer that is
// replayed as one 16-bit AXI-Stream frame, followed by an optional idle gap.
module frame_transmitter
    import packet_filter_pkg::*;
#(
    parameter  int BUF_BYTES = 256,
    localparam int PTR_W     = $clog2(BUF_BYTES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  writedata,
    input  logic        write,
    input  logic        chipselect,
    input  logic [7:0]  address,
    input  logic        read,
    output logic [7:0]  readdata,
    output logic [15:0] egress_port_tdata,
    output logic        egress_port_tvalid,
    input  logic        egress_port_tready,
    output logic        egress_port_tlast
);

    tx_state_t      state_q, state_d;
    logic [15:0]    tdata_q, tdata_d;
    logic           tvalid_q, tvalid_d;
    logic           tlast_q, tlast_d;
    logic [7:0]     readdata_q, readdata_d;
    logic [7:0]     gap_q, gap_d;
    logic [7:0]     gap_cnt_q, gap_cnt_d;
    logic [7:0]     frames_q, frames_d;
    logic           ovf_q, ovf_d;
    logic [PTR_W:0] rem_q, rem_d;

    logic           wr_en, rd_en, start_req, clear_req, data_wr;
    logic           accept_start, reload, last_hs;
    logic           buf_pop, buf_pop_two, buf_clear, buf_full, buf_empty;
    logic [7:0]     buf_b0, buf_b1, status;
    logic [PTR_W:0] buf_count, avail;

    assign wr_en     = chipselect && write;
    assign rd_en     = chipselect && read;
    assign start_req = wr_en && (address == TX_CTRL) && writedata[CTRL_START];
    assign clear_req = wr_en && (address == TX_CTRL) && writedata[CTRL_CLEAR];
    assign data_wr   = wr_en && (address == TX_DATA);

    // A combined start+clear empties the buffer first, leaving nothing to send.
    assign accept_start = (state_q == IDLE) && start_req && !clear_req && !buf_empty;
    assign reload       = (state_q == SEND) && (!tvalid_q || egress_port_tready)
                          && !(tvalid_q && tlast_q);
    assign last_hs      = (state_q == SEND) && tvalid_q && egress_port_tready && tlast_q;

    assign status = {4'b0000, ovf_q, buf_empty, buf_full, (state_q != IDLE)};

    tx_byte_buffer #(.BUF_BYTES(BUF_BYTES)) u_buf (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (buf_clear),
        .push_i      (data_wr),
        .push_data_i (writedata),
        .pop_i       (buf_pop),
        .pop_two_i   (buf_pop_two),
        .rd_byte0_o  (buf_b0),
        .rd_byte1_o  (buf_b1),
        .count_o     (buf_count),
        .full_o      (buf_full),
        .empty_o     (buf_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            readdata_q <= '0;
            gap_q      <= '0;
            gap_cnt_q  <= '0;
            frames_q   <= '0;
            ovf_q      <= 1'b0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            readdata_q <= readdata_d;
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
            frames_q   <= frames_d;
            ovf_q      <= ovf_d;
            rem_q      <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept_start) state_d = SEND;
            SEND: if (last_hs) state_d = (gap_q != 8'd0) ? GAP : IDLE;
            GAP:  if (gap_cnt_q <= 8'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        rem_d       = rem_q;
        frames_d    = frames_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        ovf_d       = ovf_q;
        readdata_d  = 8'h00;
        buf_pop     = 1'b0;
        buf_pop_two = 1'b0;
        buf_clear   = (state_q == IDLE) && clear_req;
        // The first beat sizes itself from the whole buffer; later beats from what is left of the frame.
        avail       = (state_q == IDLE) ? buf_count : rem_q;

        if (accept_start || reload) begin
            buf_pop     = 1'b1;
            buf_pop_two = (avail >= (PTR_W+1)'(2));
            tdata_d     = {buf_b0, buf_pop_two ? buf_b1 : 8'h00};
            tlast_d     = (avail <= (PTR_W+1)'(2));
            tvalid_d    = 1'b1;
            rem_d       = avail - (buf_pop_two ? (PTR_W+1)'(2) : (PTR_W+1)'(1));
        end
        if (last_hs) begin
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            frames_d  = frames_q + 8'd1;
            gap_cnt_d = gap_q;
        end
        if (state_q == GAP) begin
            gap_cnt_d = gap_cnt_q - 8'd1;
        end

        if (wr_en && (address == TX_GAP)) begin
            gap_d = writedata;
        end
        if (rd_en && (address == TX_STATUS)) begin
            ovf_d = 1'b0;
        end
        if (data_wr && buf_full) begin
            ovf_d = 1'b1;
        end

        if (rd_en) begin
            case (address)
                TX_STATUS: readdata_d = status;
                TX_FILL:   readdata_d = sat_fill(32'(buf_count));
                TX_FRAMES: readdata_d = frames_q;
                default:   readdata_d = 8'h00;
            endcase
        end
    end

    assign readdata           = readdata_q;
    assign egress_port_tdata  = tdata_q;
    assign egress_port_tvalid = tvalid_q;
    assign egress_port_tlast  = tlast_q;

endmodule

// File: tb/tb_frame_transmitter.sv
// Scoreboard bench for frame_transmitter: the driver keeps a byte-queue model of
// the buffer and queues expected beats/reads; a negedge monitor does all comparing.
module tb_frame_transmitter;
    import packet_filter_pkg::*;

    localparam int BUF = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  writedata, address;
    logic        write, chipselect, read;
    logic [7:0]  readdata;
    logic [15:0] tdata;
    logic        tvalid, tready, tlast;

    frame_transmitter #(.BUF_BYTES(BUF)) dut (
        .clk                (clk),
        .reset              (reset),
        .writedata          (writedata),
        .write              (write),
        .chipselect         (chipselect),
        .address            (address),
        .read               (read),
        .readdata           (readdata),
        .egress_port_tdata  (tdata),
        .egress_port_tvalid (tvalid),
        .egress_port_tready (tready),
        .egress_port_tlast  (tlast)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] act;
        logic [31:0] req;
    } req_t;

    req_t        dq[$];
    logic [16:0] exp_q[$];
    logic [7:0]  rd_exp[$];
    logic [7:0]  mbuf[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames_model = 0;
    int hs_count = 0;
    int last_hs_cyc = 0;
    int prev_hs_cyc = 0;
    logic model_ovf;
    int   gap_model;
    int   tr_mode;
    int   pidx;

    logic        rd_pend = 1'b0;
    logic        p_stall = 1'b0;
    logic        p_last = 1'b0;
    logic [15:0] p_data = 16'h0;
    req_t        mon_r;
    logic [16:0] mon_e;
    logic [7:0]  mon_rd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: sole owner of the check counters and of everything derived from the stream.
    always @(negedge clk) begin
        while (dq.size() > 0) begin
            mon_r = dq.pop_front();
            chk(mon_r.nm, mon_r.act, mon_r.req);
        end
        if (reset) begin
            exp_q.delete();
            rd_exp.delete();
            frames_model = 0;
            rd_pend = 1'b0;
            p_stall = 1'b0;
        end else begin
            if (rd_pend) begin
                if (rd_exp.size() == 0) begin
                    chk("read_no_expectation", 32'd1, 32'd0);
                end else begin
                    mon_rd = rd_exp.pop_front();
                    chk("readdata", 32'(readdata), 32'(mon_rd));
                end
            end else begin
                chk("readdata_idle", 32'(readdata), 32'd0);
            end
            if (p_stall) begin
                chk("stall_hold", 32'({tvalid, tlast, tdata}), 32'({1'b1, p_last, p_data}));
            end
            if (tvalid && tready) begin
                hs_count++;
                prev_hs_cyc = last_hs_cyc;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'({tlast, tdata}), 32'h1FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat", 32'({tlast, tdata}), 32'(mon_e));
                    if (mon_e[16]) frames_model++;
                end
            end
            p_stall = tvalid && !tready;
            p_data  = tdata;
            p_last  = tlast;
            rd_pend = chipselect && read;
        end
    end

    task automatic post(input string nm, input logic [31:0] act, input logic [31:0] req);
        req_t r;
        r.nm  = nm;
        r.act = act;
        r.req = req;
        dq.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (tr_mode)
            1: tready = 1'($urandom_range(0, 1));
            2: begin
                tready = ((pidx % 3) == 0);
                pidx++;
            end
            default: ;
        endcase
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [7:0] e);
        rd_exp.push_back(e);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d);
        if (mbuf.size() == BUF) model_ovf = 1'b1;
        else mbuf.push_back(d);
        bus_write(TX_DATA, d);
    endtask

    task automatic set_gap(input int g);
        gap_model = g;
        bus_write(TX_GAP, 8'(g));
    endtask

    // Everything in the model buffer becomes one frame of big-endian byte pairs.
    task automatic build_beats();
        int n;
        logic [7:0] hi, lo;
        n = mbuf.size();
        for (int i = 0; i < n; i += 2) begin
            hi = mbuf[i];
            lo = (i + 1 < n) ? mbuf[i+1] : 8'h00;
            exp_q.push_back({(i + 2 >= n), hi, lo});
        end
        mbuf.delete();
    endtask

    task automatic start_frame();
        build_beats();
        bus_write(TX_CTRL, 8'h01);
    endtask

    task automatic read_status();
        logic [7:0] e;
        e = {4'b0000, model_ovf, (mbuf.size() == 0), (mbuf.size() == BUF), 1'b0};
        bus_read(TX_STATUS, e);
        model_ovf = 1'b0;
    endtask

    task automatic read_fill();
        bus_read(TX_FILL, (mbuf.size() > 255) ? 8'd255 : 8'(mbuf.size()));
    endtask

    task automatic read_frames();
        bus_read(TX_FRAMES, 8'(frames_model));
    endtask

    task automatic wait_drain(input int extra);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        post("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (extra) tick();
    endtask

    initial begin
        int k, base, g, len;
        reset = 1'b1;
        chipselect = 1'b0;
        write = 1'b0;
        read = 1'b0;
        address = 8'h00;
        writedata = 8'h00;
        tready = 1'b0;
        tr_mode = 0;
        pidx = 0;
        model_ovf = 1'b0;
        gap_model = 0;

        repeat (3) tick();
        post("rst_tvalid", 32'(tvalid), 32'd0);
        post("rst_tlast", 32'(tlast), 32'd0);
        post("rst_tdata", 32'(tdata), 32'd0);
        post("rst_readdata", 32'(readdata), 32'd0);
        reset = 1'b0;
        tick();
        read_status();
        read_fill();
        read_frames();

        // Even-length frame, back-to-back beats
        tready = 1'b1;
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        start_frame();
        wait_drain(2);
        post("t1_consecutive", 32'(last_hs_cyc - prev_hs_cyc), 32'd1);
        read_frames();
        read_status();

        // Odd-length frame, zero-padded tail
        push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
        start_frame();
        wait_drain(2);
        read_fill();
        read_frames();

        // Back-pressure pattern 1,0,0,...
        base = hs_count;
        for (int i = 1; i <= 6; i++) push_byte(8'(i));
        pidx = 0;
        tr_mode = 2;
        start_frame();
        wait_drain(2);
        tr_mode = 0;
        tready = 1'b1;
        post("stall_handshakes", 32'(hs_count - base), 32'd3);

        // Inter-frame gap: probe with start every cycle until the next frame appears
        set_gap(5);
        tready = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i));
        start_frame();
        for (int i = 0; i < 4; i++) push_byte(8'hB0 + 8'(i));
        tready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            bus_write(TX_CTRL, 8'h01);
            k++;
        end
        k = 0;
        while (tvalid !== 1'b1 && k < 100) begin
            bus_write(TX_CTRL, 8'h01);
            k++;
        end
        post("gap_start_timeout", 32'(k >= 100), 32'd0);
        build_beats();
        post("gap_cycles", 32'(cyc - last_hs_cyc), 32'(gap_model + 2));
        wait_drain(8);
        set_gap(0);
        read_frames();

        // Overflow: BUF+2 writes, sticky flag, read-to-clear, truncated frame
        for (int i = 0; i < BUF + 2; i++) push_byte(8'(i));
        read_status();
        read_status();
        read_fill();
        tr_mode = 1;
        start_frame();
        wait_drain(2);
        tr_mode = 0;
        tready = 1'b1;
        read_fill();
        read_status();

        // Randomised frames, next frame's bytes loaded while the current one streams
        len = $urandom_range(1, 20);
        for (int i = 0; i < len; i++) push_byte(8'($urandom_range(0, 255)));
        for (int f = 0; f < 8; f++) begin
            g = $urandom_range(0, 3);
            set_gap(g);
            tr_mode = 1;
            start_frame();
            if (f < 7) begin
                len = $urandom_range(1, 20);
                for (int i = 0; i < len; i++) push_byte(8'($urandom_range(0, 255)));
            end
            wait_drain(g + 2);
        end
        tr_mode = 0;
        tready = 1'b1;
        read_frames();
        read_fill();
        read_status();

        // Reset in the middle of a 10-byte frame
        set_gap(0);
        for (int i = 0; i < 10; i++) push_byte(8'hC0 + 8'(i));
        base = hs_count;
        start_frame();
        k = 0;
        while (hs_count < base + 2 && k < 100) begin
            tick();
            k++;
        end
        post("reset_wait_timeout", 32'(k >= 100), 32'd0);
        reset = 1'b1;
        mbuf.delete();
        model_ovf = 1'b0;
        gap_model = 0;
        tick();
        reset = 1'b0;
        post("reset_tvalid", 32'(tvalid), 32'd0);
        tick();
        read_fill();
        read_frames();
        start_frame();
        repeat (3) begin
            post("empty_start_tvalid", 32'(tvalid), 32'd0);
            tick();
        end
        read_status();

        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_transmitter.md
Name: frame_transmitter

Overview:
- Host-driven frame source upstream of the frame receptor on the ingress path.
- Software writes payload bytes through an 8-bit Avalon-MM slave into an on-chip byte buffer, then starts transmission.
- The block emits the buffered bytes as one AXI-Stream frame: 16-bit beats, tlast on the final beat, honouring tready.
- An optional programmable inter-frame gap follows each frame.

Parameters:
- BUF_BYTES, 256, byte-buffer depth; power of two, 2..256.
- PTR_W, $clog2(BUF_BYTES), pointer width; derived, not overridden.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset; single clock domain
- writedata  in  8  Avalon write data
- write  in  1  Avalon write strobe
- chipselect  in  1  Avalon select
- address  in  8  Avalon register address
- read  in  1  Avalon read strobe
- readdata  out  8  Avalon read data; registered
- egress_port_tdata  out  16  stream data; first byte in [15:8]
- egress_port_tvalid  out  1  stream valid
- egress_port_tready  in  1  downstream ready
- egress_port_tlast  out  1  last beat of frame

Behaviour:
- Register map (byte address / mode):
  - 0W CTRL: bit0 = start, bit1 = clear buffer. Both are self-clearing pulses.
  - 1W DATA: pushes writedata into the buffer.
  - 2W GAP: inter-frame gap in cycles, 0..255.
  - 3R STATUS: bit0 busy, bit1 full, bit2 empty, bit3 overflow (sticky).
  - 4R FILL: buffer byte count; saturates at 255 for reads.
  - 5R FRAMES: frames sent, 8-bit, wraps 255->0.
- Reads return data 1 cycle after the chipselect&&read cycle; readdata = 0x00 in any cycle without a read. Unmapped reads return 0x00; unmapped writes are ignored.
- Reading STATUS clears overflow; a new overflow in the same cycle wins.
- Reset values: tvalid=0, tlast=0, tdata=0, readdata=0, buffer empty, GAP=0, FRAMES=0, overflow=0, state IDLE.
- Buffer is a circular byte array with rd/wr pointers and a count.
  - DATA write when full: byte dropped, overflow set.
  - DATA writes are accepted in any state; bytes written after start belong to the next frame.
- FSM states IDLE, SEND, GAP.
  - IDLE: start with count>0 latches frame_len = count, loads the first beat, enters SEND. egress_port_tvalid=1 on the following cycle.
  - IDLE: start with count=0 is ignored.
  - IDLE: clear empties the buffer (pointers and count to 0).
  - SEND: output register reloads when !tvalid || tready.
    - Each beat takes 2 bytes; beat = {buf[rd], buf[rd+1]}.
    - If 1 byte remains: beat = {buf[rd], 8'h00}.
    - tlast=1 on the beat containing byte frame_len-1.
    - tdata and tlast are held stable while tvalid && !tready.
    - With tready held high: one beat per cycle, no bubbles.
  - SEND exit: after the tlast beat handshakes, FRAMES increments, tvalid drops; go to GAP if GAP>0, else IDLE.
  - GAP: counts GAP cycles with tvalid=0, then returns to IDLE.
- start or clear outside IDLE: ignored.
- Simultaneous events:
  - A DATA write and a pop in the same cycle: count changes by +1-popped.
  - Full is evaluated before the pop, so a write to a full buffer is dropped even if a pop occurs that cycle.
- Pointer wrap-around at BUF_BYTES-1 -> 0 is transparent to the beat format.
- Reset mid-frame: tvalid drops the next cycle, buffer emptied, frame abandoned with no tlast.

Decomposition:
- Shared package packet_filter_pkg holds:
  - tx_state_t enum {IDLE, SEND, GAP};
  - register-address localparams TX_CTRL=0, TX_DATA=1, TX_GAP=2, TX_STATUS=3, TX_FILL=4, TX_FRAMES=5;
  - CTRL bit positions.
- Sub-module tx_byte_buffer: circular byte store with 1-byte push, 1- or 2-byte pop, count/full/empty.
- Top level owns the register file, FSM and output register.

Test Plan:
- Write DATA 0x11,0x22,0x33,0x44, start, tready=1 -> beats 0x1122, 0x3344 on consecutive cycles; tlast on 0x3344; FRAMES=1; empty=1.
- Write 3 bytes 0xAA,0xBB,0xCC, start -> beats 0xAABB, 0xCC00 (tlast); FILL=0.
- 6-byte frame, tready toggling 1,0,0,1,... -> tdata/tlast stable while stalled; exactly 3 handshakes in order; no duplicates.
- GAP=5, two back-to-back frames started as soon as IDLE -> exactly 5 cycles of tvalid=0 between the first tlast handshake and the next frame being startable.
- Write BUF_BYTES+2 bytes -> full=1, overflow=1, FILL saturates; STATUS read clears overflow; transmitted frame holds the first BUF_BYTES bytes only.
- Assert reset mid-SEND with a 10-byte frame, after 2 beats -> tvalid=0 next cycle; FILL=0, FRAMES=0; start with empty buffer stays IDLE.
